csr_file: RTL

Parametrised control/status register file for the 151LA pipeline. It replaces the single-register write latch with an addressed CSR bank:
- tohost register
- NUM_SCRATCH read/write scratch CSRs
- read-only cycle and instret counters

It implements the Zicsr read-modify-write operations: RW, RS and RC, each with register or immediate source. It sits in the execute stage, beside the ALU. It returns the old CSR value for rd writeback in the same cycle.

---
 rtl/csr_file.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/csr_file.sv
// csr_file: addressed control/status register bank for the 151LA execute stage.
// Provides tohost, a parametrised set of scratch CSRs and read-only cycle/instret
// counters, with Zicsr RW/RS/RC read-modify-write semantics. The old CSR value
// is returned combinationally for rd writeback in the same cycle.
module csr_file #(
    parameter int          XLEN         = 32,
    parameter int          NUM_SCRATCH  = 4,
    parameter logic [11:0] SCRATCH_BASE = 12'h7C0,
    parameter int          CNT_WIDTH    = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            csr_en,
    input  logic [1:0]      csr_op,
    input  logic            csr_imm,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      zimm,
    input  logic            retire,
    output logic [XLEN-1:0] rd_data,
    output logic            illegal,
    output logic [XLEN-1:0] tohost
);

    localparam logic [1:0]  OP_NOP = 2'b00;
    localparam logic [1:0]  OP_RW  = 2'b01;
    localparam logic [1:0]  OP_RS  = 2'b10;
    localparam logic [1:0]  OP_RC  = 2'b11;

    localparam logic [11:0] ADDR_TOHOST    = 12'h51E;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [XLEN-1:0]        tohost_q;
    logic [XLEN-1:0]        scratch_q [NUM_SCRATCH];
    logic [CNT_WIDTH-1:0]   cycle_cnt;
    logic [CNT_WIDTH-1:0]   instret_cnt;

    logic [NUM_SCRATCH-1:0] scratch_sel;
    logic                   hit_tohost;
    logic                   hit_scratch;
    logic                   hit_counter;
    logic [XLEN-1:0]        old_val;
    logic [XLEN-1:0]        src;
    logic [XLEN-1:0]        new_val;
    logic                   would_write;
    logic                   we;

    assign tohost = tohost_q;

    // Address decode and old-value mux; unmapped addresses read as zero.
    always_comb begin
        scratch_sel = '0;
        hit_scratch = 1'b0;
        hit_tohost  = (csr_addr == ADDR_TOHOST);
        hit_counter = 1'b0;
        old_val     = '0;
        if (hit_tohost) begin
            old_val = tohost_q;
        end
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (csr_addr == 12'(SCRATCH_BASE + 12'(i))) begin
                scratch_sel[i] = 1'b1;
                hit_scratch    = 1'b1;
                old_val        = scratch_q[i];
            end
        end
        case (csr_addr)
            ADDR_CYCLE: begin
                hit_counter = 1'b1;
                old_val     = cycle_cnt[XLEN-1:0];
            end
            ADDR_CYCLEH: begin
                hit_counter = 1'b1;
                old_val     = XLEN'(cycle_cnt >> XLEN);
            end
            ADDR_INSTRET: begin
                hit_counter = 1'b1;
                old_val     = instret_cnt[XLEN-1:0];
            end
            ADDR_INSTRETH: begin
                hit_counter = 1'b1;
                old_val     = XLEN'(instret_cnt >> XLEN);
            end
            default: ;
        endcase
    end

    assign rd_data = old_val;
    assign src     = csr_imm ? {{(XLEN-5){1'b0}}, zimm} : rs1_data;

    // Read-modify-write result for the selected Zicsr operation.
    always_comb begin
        new_val = old_val;
        case (csr_op)
            OP_RW:   new_val = src;
            OP_RS:   new_val = old_val | src;
            OP_RC:   new_val = old_val & ~src;
            default: new_val = old_val;
        endcase
    end

    // Set/clear with a zero source is a pure read, so it may target a counter.
    assign would_write = csr_en && !stall && (csr_op != OP_NOP) &&
                         ((csr_op == OP_RW) || (src != '0));
    assign illegal     = csr_en && (!(hit_tohost || hit_scratch || hit_counter) ||
                                    (hit_counter && would_write));
    assign we          = would_write && !illegal;

    // Writable CSRs: tohost and scratch bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            tohost_q <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= '0;
            end
        end else if (we) begin
            if (hit_tohost) begin
                tohost_q <= new_val;
            end
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (scratch_sel[i]) begin
                    scratch_q[i] <= new_val;
                end
            end
        end
    end

    // Free-running cycle counter and stall-gated retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_ONE;
            if (retire && !stall) begin
                instret_cnt <= instret_cnt + CNT_ONE;
            end
        end
    end

endmodule
